// File: rtl/main_scu_bac_int_event_capture.sv
// main_scu_bac_int_event_capture: per-source interrupt event front end (sync, debounce, trigger)
// Ports:
//   clk_i, resetn_i     clock, asynchronous active-low reset
//   src_i               raw asynchronous event inputs, one per source
//   mode_i              per-source trigger mode [2i+1:2i]: 00 off, 01 level-high, 10 rising, 11 falling
//   debounce_thr_i      global debounce threshold D (quasi-static)
//   hw_set_o            registered hardware-set requests to the interrupt handler
//   filt_status_o       current filtered level per source
// Macro SCU_INT_CAPTURE_DEBOUNCE_EN enables the debounce filter; without it the
// filtered level follows the synchronized level every cycle (same timing as D=0).
module main_scu_bac_int_event_capture #(
  parameter int p_src_num     = 32,
  parameter int p_sync_stages = 2,
  parameter int p_debounce_w  = 8
) (
  input  logic                   clk_i,
  input  logic                   resetn_i,
  input  logic [p_src_num-1:0]   src_i,
  input  logic [2*p_src_num-1:0] mode_i,
  input  logic [p_debounce_w-1:0] debounce_thr_i,
  output logic [p_src_num-1:0]   hw_set_o,
  output logic [p_src_num-1:0]   filt_status_o
);
  logic [p_sync_stages-1:0][p_src_num-1:0] sync_q;
  logic [p_src_num-1:0] s, filt_q, filt_d, filt_prev_q, hw_set_d;
  assign s = sync_q[p_sync_stages-1];
  always_ff @(posedge clk_i or negedge resetn_i)
    if (!resetn_i) sync_q <= '0;
    else sync_q <= {sync_q[p_sync_stages-2:0], src_i};
`ifdef SCU_INT_CAPTURE_DEBOUNCE_EN
  logic [p_src_num-1:0][p_debounce_w-1:0] cnt_q, cnt_d;
  // >= rather than == so a threshold lowered mid-count commits immediately
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    for (int i = 0; i < p_src_num; i++)
      if (s[i] == filt_q[i]) cnt_d[i] = '0;
      else if (cnt_q[i] >= debounce_thr_i) begin
        filt_d[i] = s[i];
        cnt_d[i]  = '0;
      end else cnt_d[i] = cnt_q[i] + 1'b1;
  end
  always_ff @(posedge clk_i or negedge resetn_i)
    if (!resetn_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  logic unused_thr;
  assign unused_thr = ^debounce_thr_i;
  assign filt_d = s;
`endif
  always_comb begin
    hw_set_d = '0;
    for (int i = 0; i < p_src_num; i++)
      hw_set_d[i] = mode_i[2*i+1] ? (mode_i[2*i] ? ~filt_q[i] & filt_prev_q[i] : filt_q[i] & ~filt_prev_q[i])
                                  : (mode_i[2*i] & filt_q[i]);
  end
  always_ff @(posedge clk_i or negedge resetn_i)
    if (!resetn_i) begin
      filt_q      <= '0;
      filt_prev_q <= '0;
      hw_set_o    <= '0;
    end else begin
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      hw_set_o    <= hw_set_d;
    end
  assign filt_status_o = filt_q;
endmodule

// File: tb/tb_main_scu_bac_int_event_capture.sv
// tb_main_scu_bac_int_event_capture: randomized check of the event front end against a history-based model
module tb_main_scu_bac_int_event_capture;
  localparam int N = 32, P = 2, W = 8, H = 4096;
  logic clk = 1'b0, resetn = 1'b0;
  logic [N-1:0] src, hw, filt;
  logic [2*N-1:0] mode;
  logic [W-1:0] thr;
  int vectors = 0, miscompares = 0;
  logic [N-1:0] shist [H];
  logic [N-1:0] fhist [H];
  int run [N];
  int n;
  logic [N-1:0] exp_hw;
  main_scu_bac_int_event_capture #(.p_src_num(N), .p_sync_stages(P), .p_debounce_w(W)) dut (
    .clk_i(clk), .resetn_i(resetn), .src_i(src), .mode_i(mode),
    .debounce_thr_i(thr), .hw_set_o(hw), .filt_status_o(filt)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [N-1:0] got, logic [N-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [N-1:0] sh(int k);
    return k < 1 ? '0 : shist[k];
  endfunction
  function automatic logic [N-1:0] fh(int k);
    return k < 1 ? '0 : fhist[k];
  endfunction
  function automatic int deff();
`ifdef SCU_INT_CAPTURE_DEBOUNCE_EN
    return int'(thr);
`else
    return 0;
`endif
  endfunction
  task automatic model_reset();
    n = 0;
    exp_hw = '0;
    for (int i = 0; i < N; i++) run[i] = 0;
  endtask
  // Edge n: src sampled into history; the level seen by the filter is the one
  // sampled P edges earlier; the filtered level flips once it has disagreed for
  // D+1 consecutive samples; requests derive from filtered levels one and two edges back.
  task automatic edge_model();
    logic [N-1:0] s, f, cur, prv;
    n++;
    shist[n] = src;
    s = sh(n - P);
    f = fh(n - 1);
    for (int i = 0; i < N; i++)
      if (s[i] != f[i]) begin
        run[i]++;
        if (run[i] >= deff() + 1) begin
          f[i] = s[i];
          run[i] = 0;
        end
      end else run[i] = 0;
    fhist[n] = f;
    cur = fh(n - 1);
    prv = fh(n - 2);
    for (int i = 0; i < N; i++)
      case (mode[2*i+:2])
        2'b00: exp_hw[i] = 1'b0;
        2'b01: exp_hw[i] = cur[i];
        2'b10: exp_hw[i] = cur[i] && !prv[i];
        default: exp_hw[i] = !cur[i] && prv[i];
      endcase
  endtask
  task automatic tick();
    @(posedge clk);
    edge_model();
    @(negedge clk);
    check("hw_set", hw, exp_hw);
    check("filt", filt, fh(n));
  endtask
  task automatic do_reset(int cycles);
    resetn = 1'b0;
    repeat (cycles) @(negedge clk);
    check("rst_hw", hw, '0);
    check("rst_filt", filt, '0);
    resetn = 1'b1;
    model_reset();
  endtask
  initial begin
    src = '1;
    mode = {N{2'b10}};
    thr = '0;
    model_reset();
    @(negedge clk);
    do_reset(3);
    repeat (3) tick();
    check("rst_pre_pulse", hw, '0);
    tick();
    check("rst_pulse", hw, '1);
    tick();
    check("rst_pulse_end", hw, '0);
    src = '0;
    repeat (8) tick();
    thr = 8'd3;
    src[0] = 1'b1;
    repeat (10) tick();
    src[5] = 1'b1;
    repeat (3) tick();
    src[5] = 1'b0;
    repeat (8) tick();
    src[5] = 1'b1;
    repeat (4) tick();
    src[5] = 1'b0;
    repeat (10) tick();
    thr = '0;
    mode[15:14] = 2'b11;
    src[7] = 1'b1;
    repeat (10) tick();
    src[7] = 1'b0;
    repeat (6) tick();
    mode[15:14] = 2'b01;
    src[7] = 1'b1;
    repeat (10) tick();
    src[7] = 1'b0;
    repeat (6) tick();
    thr = 8'd10;
    src[9] = 1'b1;
    repeat (8) tick();
    thr = 8'd2;
    repeat (4) tick();
    thr = 8'd5;
    src[3] = 1'b1;
    repeat (4) tick();
    do_reset(2);
    repeat (12) tick();
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(3) == 0) src[$urandom_range(N-1)] ^= 1'b1;
      if ($urandom_range(7) == 0) src[$urandom_range(N-1)] ^= 1'b1;
      if ($urandom_range(29) == 0) mode[2*$urandom_range(N-1)+:2] = 2'($urandom_range(3));
      if ($urandom_range(99) == 0) thr = W'($urandom_range(4));
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
